// File: rtl/fifo_sync1_if.sv
// rtl/fifo_sync1_if.sv - producer/consumer handshake bundle for fifo_sync1
interface fifo_sync1_if #(
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = 4
) ();
    logic                  fifo_wr_en;
    logic [WIDTH_DATA-1:0] fifo_wr_data;
    logic                  fifo_rd_en;
    logic [WIDTH_DATA-1:0] fifo_rd_data;
    logic                  fifo_rd_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_afull;
    logic                  fifo_aempty;
    logic [WIDTH_ADDR:0]   fifo_cnt;
    logic                  fifo_wr_err;
    logic                  fifo_rd_err;

    modport master (
        output fifo_wr_en, fifo_wr_data, fifo_rd_en,
        input  fifo_rd_data, fifo_rd_valid, fifo_full, fifo_empty,
               fifo_afull, fifo_aempty, fifo_cnt, fifo_wr_err, fifo_rd_err
    );

    modport slave (
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
        output fifo_rd_data, fifo_rd_valid, fifo_full, fifo_empty,
               fifo_afull, fifo_aempty, fifo_cnt, fifo_wr_err, fifo_rd_err
    );
endinterface

// File: rtl/fifo_sync1.sv
// rtl/fifo_sync1.sv - parametrised single-clock FIFO; FIFO_SYNC1_FWFT_EN selects first-word-fall-through
module fifo_sync1 #(
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = 4,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic        sys_clk,
    input  logic        srst,
    fifo_sync1_if.slave fif
);
    localparam logic [WIDTH_ADDR:0]   DEPTH_C  = (WIDTH_ADDR+1)'(DEPTH);
    localparam logic [WIDTH_ADDR:0]   AFULL_C  = (WIDTH_ADDR+1)'(AFULL_TH);
    localparam logic [WIDTH_ADDR:0]   AEMPTY_C = (WIDTH_ADDR+1)'(AEMPTY_TH);
    localparam logic [WIDTH_ADDR:0]   CNT_ONE  = {{WIDTH_ADDR{1'b0}}, 1'b1};
    localparam logic [WIDTH_ADDR-1:0] PTR_ONE  = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_ADDR-1:0] PTR_LAST = WIDTH_ADDR'(DEPTH - 1);

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [WIDTH_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH_ADDR:0]   cnt_q, cnt_d;
    logic                  wr_err_q, rd_err_q;
    logic                  full, empty;
    logic                  wr_ok, rd_ok;

    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);

    // Requests in a reset cycle are dropped, so they neither store nor move pointers.
    assign wr_ok = fif.fifo_wr_en & ~full  & ~srst;
    assign rd_ok = fif.fifo_rd_en & ~empty & ~srst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= fif.fifo_wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wr_err_q <= fif.fifo_wr_en & full;
            rd_err_q <= fif.fifo_rd_en & empty;
        end
    end

`ifdef FIFO_SYNC1_FWFT_EN
    assign fif.fifo_rd_data  = mem_q[rd_ptr_q];
    assign fif.fifo_rd_valid = ~empty;
`else
    logic [WIDTH_DATA-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge sys_clk) begin
        if (srst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign fif.fifo_rd_data  = rd_data_q;
    assign fif.fifo_rd_valid = rd_valid_q;
`endif

    assign fif.fifo_full   = full;
    assign fif.fifo_empty  = empty;
    assign fif.fifo_afull  = (cnt_q >= AFULL_C);
    assign fif.fifo_aempty = (cnt_q <= AEMPTY_C);
    assign fif.fifo_cnt    = cnt_q;
    assign fif.fifo_wr_err = wr_err_q;
    assign fif.fifo_rd_err = rd_err_q;
endmodule

// File: tb/tb_fifo_sync1.sv
// tb/tb_fifo_sync1.sv - directed bench for fifo_sync1 at DEPTH=8 and DEPTH=6
module tb_fifo_sync1;
    logic sys_clk = 1'b0;
    logic srst;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    fifo_sync1_if #(.WIDTH_DATA(8), .WIDTH_ADDR(3)) if8 ();
    fifo_sync1_if #(.WIDTH_DATA(8), .WIDTH_ADDR(3)) if6 ();

    fifo_sync1 #(.WIDTH_DATA(8), .WIDTH_ADDR(3), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut8 (
        .sys_clk (sys_clk),
        .srst    (srst),
        .fif     (if8)
    );

    fifo_sync1 #(.WIDTH_DATA(8), .WIDTH_ADDR(3), .DEPTH(6), .AFULL_TH(4), .AEMPTY_TH(1)) u_dut6 (
        .sys_clk (sys_clk),
        .srst    (srst),
        .fif     (if6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step8(input logic wr, input logic [7:0] d, input logic rd);
        if8.fifo_wr_en   = wr;
        if8.fifo_wr_data = d;
        if8.fifo_rd_en   = rd;
        @(posedge sys_clk);
        #1;
        if8.fifo_wr_en = 1'b0;
        if8.fifo_rd_en = 1'b0;
    endtask

    task automatic pop8(input logic [7:0] exp, input string tag);
`ifdef FIFO_SYNC1_FWFT_EN
        check({tag, "_valid"}, 32'(if8.fifo_rd_valid), 32'd1);
        check({tag, "_data"}, 32'(if8.fifo_rd_data), 32'(exp));
        step8(1'b0, 8'h00, 1'b1);
`else
        step8(1'b0, 8'h00, 1'b1);
        check({tag, "_valid"}, 32'(if8.fifo_rd_valid), 32'd1);
        check({tag, "_data"}, 32'(if8.fifo_rd_data), 32'(exp));
`endif
    endtask

    task automatic d6_run();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] exp;
        logic       wr, rd, wok, rok;
        int         wr_n, rd_n, mcnt, c;
        wr_n = 0; rd_n = 0; mcnt = 0; c = 0;
        while (rd_n < 20 && c < 200) begin
            wr  = (wr_n < 20) && (c % 4 != 3);
            rd  = (c % 3 != 0);
            d   = 8'h40 + 8'(wr_n);
            wok = wr && (mcnt < 6);
            rok = rd && (mcnt > 0);
`ifdef FIFO_SYNC1_FWFT_EN
            if (mcnt > 0) check("d6_head", 32'(if6.fifo_rd_data), 32'(q[0]));
`endif
            if6.fifo_wr_en   = wr;
            if6.fifo_wr_data = d;
            if6.fifo_rd_en   = rd;
            @(posedge sys_clk);
            #1;
            if (wok) begin
                q.push_back(d);
                wr_n++;
            end
            if (rok) begin
                exp = q.pop_front();
                rd_n++;
`ifndef FIFO_SYNC1_FWFT_EN
                check("d6_data", 32'(if6.fifo_rd_data), 32'(exp));
`endif
            end
`ifndef FIFO_SYNC1_FWFT_EN
            check("d6_valid", 32'(if6.fifo_rd_valid), 32'(rok));
`endif
            mcnt = mcnt + (wok ? 1 : 0) - (rok ? 1 : 0);
            check("d6_cnt", 32'(if6.fifo_cnt), 32'(mcnt));
            check("d6_cnt_max", 32'(if6.fifo_cnt > 4'd6), 32'd0);
            check("d6_wr_err", 32'(if6.fifo_wr_err), 32'(wr && !wok));
            c++;
        end
        if6.fifo_wr_en = 1'b0;
        if6.fifo_rd_en = 1'b0;
        check("d6_drained", 32'(rd_n), 32'd20);
    endtask

    initial begin
        srst = 1'b1;
        if8.fifo_wr_en = 1'b0; if8.fifo_wr_data = 8'h00; if8.fifo_rd_en = 1'b0;
        if6.fifo_wr_en = 1'b0; if6.fifo_wr_data = 8'h00; if6.fifo_rd_en = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        srst = 1'b0;

        check("rst_cnt", 32'(if8.fifo_cnt), 32'd0);
        check("rst_empty", 32'(if8.fifo_empty), 32'd1);
        check("rst_aempty", 32'(if8.fifo_aempty), 32'd1);
        check("rst_full", 32'(if8.fifo_full), 32'd0);
        check("rst_afull", 32'(if8.fifo_afull), 32'd0);
        check("rst_errs", 32'({if8.fifo_wr_err, if8.fifo_rd_err}), 32'd0);
`ifndef FIFO_SYNC1_FWFT_EN
        check("rst_valid", 32'(if8.fifo_rd_valid), 32'd0);
        check("rst_data", 32'(if8.fifo_rd_data), 32'd0);
`else
        check("rst_valid", 32'(if8.fifo_rd_valid), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            step8(1'b1, 8'h11 + 8'(i), 1'b0);
            check("fill_cnt", 32'(if8.fifo_cnt), 32'(i + 1));
            check("fill_afull", 32'(if8.fifo_afull), 32'(i + 1 >= 6));
            check("fill_aempty", 32'(if8.fifo_aempty), 32'(i + 1 <= 2));
        end
        check("fill_full", 32'(if8.fifo_full), 32'd1);
        check("fill_empty", 32'(if8.fifo_empty), 32'd0);

        step8(1'b1, 8'h99, 1'b0);
        check("ovf_wr_err", 32'(if8.fifo_wr_err), 32'd1);
        check("ovf_cnt", 32'(if8.fifo_cnt), 32'd8);
        step8(1'b0, 8'h00, 1'b0);
        check("ovf_wr_err_clr", 32'(if8.fifo_wr_err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            pop8(8'h11 + 8'(i), "drain");
            check("drain_cnt", 32'(if8.fifo_cnt), 32'(7 - i));
        end
        check("drain_empty", 32'(if8.fifo_empty), 32'd1);
        check("drain_aempty", 32'(if8.fifo_aempty), 32'd1);

        step8(1'b0, 8'h00, 1'b1);
        check("udf_rd_err", 32'(if8.fifo_rd_err), 32'd1);
        check("udf_valid", 32'(if8.fifo_rd_valid), 32'd0);
`ifndef FIFO_SYNC1_FWFT_EN
        check("udf_data_hold", 32'(if8.fifo_rd_data), 32'h18);
`endif
        step8(1'b0, 8'h00, 1'b0);
        check("udf_rd_err_clr", 32'(if8.fifo_rd_err), 32'd0);

        for (int i = 0; i < 8; i++) step8(1'b1, 8'h21 + 8'(i), 1'b0);
        check("both_full_pre", 32'(if8.fifo_full), 32'd1);
`ifdef FIFO_SYNC1_FWFT_EN
        check("both_full_head", 32'(if8.fifo_rd_data), 32'h21);
        step8(1'b1, 8'h77, 1'b1);
`else
        step8(1'b1, 8'h77, 1'b1);
        check("both_full_valid", 32'(if8.fifo_rd_valid), 32'd1);
        check("both_full_data", 32'(if8.fifo_rd_data), 32'h21);
`endif
        check("both_full_wr_err", 32'(if8.fifo_wr_err), 32'd1);
        check("both_full_cnt", 32'(if8.fifo_cnt), 32'd7);
        for (int i = 1; i < 8; i++) pop8(8'h21 + 8'(i), "both_full_rest");
        check("both_full_emptied", 32'(if8.fifo_empty), 32'd1);

        step8(1'b1, 8'h5A, 1'b1);
        check("both_empty_rd_err", 32'(if8.fifo_rd_err), 32'd1);
        check("both_empty_cnt", 32'(if8.fifo_cnt), 32'd1);
`ifndef FIFO_SYNC1_FWFT_EN
        check("both_empty_valid", 32'(if8.fifo_rd_valid), 32'd0);
`endif
        pop8(8'h5A, "both_empty_word");
        check("both_empty_cnt0", 32'(if8.fifo_cnt), 32'd0);

        for (int i = 0; i < 4; i++) step8(1'b1, 8'h30 + 8'(i), 1'b0);
        check("half_cnt", 32'(if8.fifo_cnt), 32'd4);
        srst = 1'b1;
        step8(1'b1, 8'hEE, 1'b0);
        srst = 1'b0;
        check("mid_rst_cnt", 32'(if8.fifo_cnt), 32'd0);
        check("mid_rst_empty", 32'(if8.fifo_empty), 32'd1);
        check("mid_rst_wr_err", 32'(if8.fifo_wr_err), 32'd0);
        step8(1'b0, 8'h00, 1'b1);
        check("post_rst_rd_err", 32'(if8.fifo_rd_err), 32'd1);
        check("post_rst_cnt", 32'(if8.fifo_cnt), 32'd0);

        step8(1'b1, 8'hA5, 1'b0);
`ifdef FIFO_SYNC1_FWFT_EN
        check("fwft_valid", 32'(if8.fifo_rd_valid), 32'd1);
        check("fwft_data", 32'(if8.fifo_rd_data), 32'hA5);
        step8(1'b0, 8'h00, 1'b1);
        check("fwft_valid_clr", 32'(if8.fifo_rd_valid), 32'd0);
`else
        check("std_no_valid", 32'(if8.fifo_rd_valid), 32'd0);
        pop8(8'hA5, "std_a5");
        step8(1'b0, 8'h00, 1'b0);
        check("std_valid_clr", 32'(if8.fifo_rd_valid), 32'd0);
`endif

        d6_run();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
